div_unsigned_seq: RTL and testbench



---
 rtl/div_unsigned_seq.sv | 182 ++++++++++++++++++
 tb/tb_div_unsigned_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unsigned_seq.sv
// div_unsigned_seq: iterative unsigned fixed-point divider, out = in1 / in2.
// Restoring radix-2 division, one quotient bit per clock, start/valid handshake.
// Both operands are aligned to a common binary point by a left shift of one of
// them. Integer division of the aligned values then yields the quotient with
// WFO fraction bits and exact truncation.
// Optional build macro: DIV_ROUND_NEAREST_EN adds a guard bit and rounds half up.
module div_unsigned_seq #(
  parameter int WI1 = 2,
  parameter int WF1 = 15,
  parameter int WI2 = 1,
  parameter int WF2 = 6,
  parameter int WIO = 1,
  parameter int WFO = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 busy,
  output logic                 valid,
  output logic [WIO+WFO-1:0]   out,
  output logic                 dz,
  output logic                 ovf
);

  localparam int W   = WIO + WFO;
  // Align binary points: dividend gets WF2+WFO fraction bits relative to the divisor.
  localparam int SHN = (WF2 + WFO >= WF1) ? (WF2 + WFO - WF1) : 0;
  localparam int SHD = (WF1 > WF2 + WFO) ? (WF1 - WF2 - WFO) : 0;
`ifdef DIV_ROUND_NEAREST_EN
  localparam int GB  = 1;
`else
  localparam int GB  = 0;
`endif
  localparam int ITER = W + GB;
  localparam int RW   = WI1 + WF1 + SHN + WI2 + WF2 + SHD + W + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   dsh_q, dsh_d;
  logic [ITER-1:0] quo_q, quo_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    out_q, out_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic            dzp_q, dzp_d;

  logic [RW-1:0]   num_s;
  logic [RW-1:0]   den_s;
  logic            ovf_pre_s;
  logic            bit_s;
  logic [ITER-1:0] quo_nx_s;

  // Aligned operands and up-front detection of a quotient that cannot fit in W bits.
  always_comb begin
    num_s     = RW'(in1) << (SHN + GB);
    den_s     = RW'(in2) << SHD;
    ovf_pre_s = (num_s >= (den_s << ITER));
  end

  // Next-state, datapath and result computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dsh_d    = dsh_q;
    quo_d    = quo_q;
    valid_d  = 1'b0;
    out_d    = out_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    dzp_d    = dzp_q;
    bit_s    = 1'b0;
    quo_nx_s = quo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (in2 == '0) begin
            dzp_d   = 1'b1;
            state_d = DONE;
          end else if (ovf_pre_s) begin
            dzp_d   = 1'b0;
            state_d = DONE;
          end else begin
            dzp_d   = 1'b0;
            rem_d   = num_s;
            dsh_d   = den_s << (ITER - 1);
            quo_d   = '0;
            cnt_d   = CW'(ITER - 1);
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          bit_s = 1'b1;
        end else begin
          bit_s = 1'b0;
        end
        quo_nx_s = (quo_q << 1) | ITER'(bit_s);
        quo_d    = quo_nx_s;
        dsh_d    = dsh_q >> 1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          valid_d = 1'b1;
`ifdef DIV_ROUND_NEAREST_EN
          // Guard bit set on an all-ones quotient would wrap: saturate and flag.
          if ((&quo_nx_s[ITER-1:1]) && quo_nx_s[0]) begin
            out_d = {W{1'b1}};
            ovf_d = 1'b1;
          end else begin
            out_d = quo_nx_s[ITER-1:1] + W'(quo_nx_s[0]);
            ovf_d = 1'b0;
          end
`else
          out_d = quo_nx_s;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b1;
        out_d   = {W{1'b1}};
        dz_d    = dzp_q;
        ovf_d   = ~dzp_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsh_q   <= '0;
      quo_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dzp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      quo_q   <= quo_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      dzp_q   <= dzp_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign out   = out_q;
  assign dz    = dz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Self-checking bench for div_unsigned_seq at default parameters.
// Expected results come from a reference model and are queued at launch time.
// A negedge monitor pops the queue on every valid pulse and compares the result.
module tb_div_unsigned_seq;

  localparam int W = 6;
`ifdef DIV_ROUND_NEAREST_EN
  localparam int LAT = W + 1;
  localparam logic [5:0] RND_EXP = 6'h2B;
`else
  localparam int LAT = W;
  localparam logic [5:0] RND_EXP = 6'h2A;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [16:0] in1 = 17'h0;
  logic [6:0]  in2 = 7'h0;
  logic        busy, valid, dz, ovf;
  logic [5:0]  out;

  typedef struct {
    logic [5:0] out;
    logic       dz;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcount = 0;

  div_unsigned_seq dut (
    .CLK(CLK), .RST(RST), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .valid(valid), .out(out), .dz(dz), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  // Free-running edge counter used for latency checks.
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: Q = floor(in1/2^15 / (in2/2^6) * 2^5) = floor(in1*2^11 / (in2*2^15)).
  function automatic exp_t model(input logic [16:0] a, input logic [6:0] b, input int now);
    exp_t   e;
    longint num, den, q, q2, r;
    num = longint'(a) * 64'd2048;
    den = longint'(b) * 64'd32768;
    e.dz = 1'b0; e.ovf = 1'b0;
    if (b == 7'd0) begin
      e.out = 6'h3F; e.dz = 1'b1; e.cyc = now + 2;
    end else begin
      q = num / den;
      if (q >= 64) begin
        e.out = 6'h3F; e.ovf = 1'b1; e.cyc = now + 2;
      end else begin
`ifdef DIV_ROUND_NEAREST_EN
        q2 = (2 * num) / den;
        r  = q2 / 2 + q2 % 2;
        if (r > 63) begin e.out = 6'h3F; e.ovf = 1'b1; end
        else e.out = 6'(r);
`else
        e.out = 6'(q);
`endif
        e.cyc = now + 1 + LAT;
      end
    end
    return e;
  endfunction

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST && valid) begin
      exp_t e;
      vcount++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got valid with out=%h, required no valid", out);
      end else begin
        e = sb.pop_front();
        if (out !== e.out) begin
          errors++;
          $display("FAIL sb_out: got %h, required %h", out, e.out);
        end
        checks++;
        if (dz !== e.dz) begin
          errors++;
          $display("FAIL sb_dz: got %b, required %b", dz, e.dz);
        end
        checks++;
        if (ovf !== e.ovf) begin
          errors++;
          $display("FAIL sb_ovf: got %b, required %b", ovf, e.ovf);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL sb_latency: valid at edge %0d, required edge %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Caller is at a negedge; drive one start cycle, return at the next negedge.
  task automatic launch(input logic [16:0] a, input logic [6:0] b, input bit push);
    in1 = a; in2 = b; start = 1'b1;
    if (push) sb.push_back(model(a, b, cyc));
    @(negedge CLK);
    start = 1'b0;
    in1 = 17'($urandom); in2 = 7'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d busy=%b, required 0 and 0", name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, valid, out, dz, ovf} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0", {busy, valid, out, dz, ovf});
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int bc = 0;
    launch(17'h0C000, 7'h60, 1'b1);
    while (busy && bc < 20) begin bc++; @(negedge CLK); end
    checks++;
    if (bc != LAT) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d, required %0d", bc, LAT);
    end
    checks++;
    if (valid !== 1'b1 || out !== 6'h20) begin
      errors++;
      $display("FAIL basic_result: got valid=%b out=%h, required valid=1 out=20", valid, out);
    end
    wait_drain("basic");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    launch(17'h18800, 7'h70, 1'b1);
    while (!valid && n < 20) begin n++; @(negedge CLK); end
    checks++;
    if (valid !== 1'b1 || out !== 6'h38) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b out=%h, required 1 and 38", valid, out);
    end
    launch(17'h12C00, 7'h50, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_drain("b2b");
    checks++;
    if (out !== 6'h3C) begin
      errors++;
      $display("FAIL b2b_second: got %h, required 3c", out);
    end
  endtask

  task automatic test_div_zero();
    launch(17'h1ABCD, 7'h00, 1'b1);
    @(negedge CLK);
    checks++;
    if (valid !== 1'b1 || out !== 6'h3F || dz !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL dz_result: got v=%b out=%h dz=%b ovf=%b, required 1 3f 1 0", valid, out, dz, ovf);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (dz !== 1'b1) begin
      errors++;
      $display("FAIL dz_hold: got %b, required 1", dz);
    end
    launch(17'h08000, 7'h30, 1'b1);
    checks++;
    if (dz !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dz_clear: got dz=%b busy=%b, required 0 1", dz, busy);
    end
    wait_drain("dz");
    launch(17'h00000, 7'h15, 1'b1);
    wait_drain("zero_dividend");
    checks++;
    if (out !== 6'h00) begin
      errors++;
      $display("FAIL zero_dividend: got %h, required 00", out);
    end
  endtask

  task automatic test_overflow();
    launch(17'h10000, 7'h20, 1'b1);
    @(negedge CLK);
    checks++;
    if (valid !== 1'b1 || out !== 6'h3F || ovf !== 1'b1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL ovf_result: got v=%b out=%h ovf=%b dz=%b, required 1 3f 1 0", valid, out, ovf, dz);
    end
    wait_drain("ovf");
  endtask

  task automatic test_round();
    launch(17'h08000, 7'h30, 1'b1);
    wait_drain("round");
    checks++;
    if (out !== RND_EXP) begin
      errors++;
      $display("FAIL round_result: got %h, required %h", out, RND_EXP);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [16:0] a;
      logic [6:0]  b;
      a = 17'($urandom);
      b = (i % 6 == 5) ? 7'd0 : 7'($urandom);
      if (i % 4 == 0) b = 7'($urandom_range(64, 127));
      launch(a, b, 1'b1);
      wait_drain("random");
    end
  endtask

  task automatic test_abort();
    int v0;
    // A start while busy is ignored: exactly one result comes back.
    v0 = vcount;
    launch(17'h18800, 7'h70, 1'b1);
    in1 = 17'h10000; in2 = 7'h00; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_drain("ignore");
    checks++;
    if (vcount != v0 + 1 || out !== 6'h38) begin
      errors++;
      $display("FAIL ignore_start: got %0d valids out=%h, required 1 valid out=38", vcount - v0, out);
    end
    launch(17'h00005, 7'h00, 1'b1);
    wait_drain("pre_abort");
    // Abort mid-operation with reset.
    v0 = vcount;
    launch(17'h0C000, 7'h60, 1'b0);
    in1 = 17'h00100; in2 = 7'h40; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({busy, valid, out, dz, ovf} !== 10'b0) begin
      errors++;
      $display("FAIL abort_reset: got %b, required 0", {busy, valid, out, dz, ovf});
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if (vcount != v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d valids busy=%b, required 0 and 0", vcount - v0, busy);
    end
    launch(17'h0C000, 7'h60, 1'b1);
    wait_drain("post_abort");
    checks++;
    if (out !== 6'h20) begin
      errors++;
      $display("FAIL post_abort: got %h, required 20", out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_round();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
